// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache: direct-mapped write-back byte cache, 8 x 4-byte lines,
// with block write-back / fetch on a 32-bit memory port.  Rev 1.0
// ============================================================================
module data_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [7:0]  r_valid;
  logic [7:0]  r_dirty;
  logic [2:0]  r_tag  [8];
  logic [31:0] r_data [8];
  logic [31:0] r_fetch_block;

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic [4:0]  w_bit_lo;
  logic [31:0] w_line;
  logic        w_request;
  logic        w_hit;
  logic        w_write_hit;

  assign w_tag       = ADDRESS[7:5];
  assign w_index     = ADDRESS[4:2];
  assign w_offset    = ADDRESS[1:0];
  assign w_bit_lo    = {w_offset, 3'b000};
  assign w_line      = r_data[w_index];
  assign w_request   = READ | WRITE;
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // WRITE wins when both strobes are high
  assign w_write_hit = (r_state == ST_IDLE) && WRITE && w_hit;

  assign BUSYWAIT = w_request && !((r_state == ST_IDLE) && w_hit);
  assign READDATA = READ ? w_line[w_bit_lo +: 8] : 8'h00;

  always_comb begin
    w_next_state  = r_state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = {w_tag, w_index};
    MEM_WRITEDATA = w_line;
    case (r_state)
      ST_IDLE: begin
        if (w_request && !w_hit) begin
          if (r_valid[w_index] && r_dirty[w_index])
            w_next_state = ST_WRITEBACK;
          else
            w_next_state = ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {r_tag[w_index], w_index};
        if (!MEM_BUSYWAIT)
          w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT)
          w_next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid <= 8'h00;
      r_dirty <= 8'h00;
    end else if (r_state == ST_UPDATE) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Line payload and tags need no reset: an invalid line is never used
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if ((r_state == ST_FETCH) && !MEM_BUSYWAIT)
        r_fetch_block <= MEM_READDATA;
      if (r_state == ST_UPDATE) begin
        r_data[w_index] <= r_fetch_block;
        r_tag[w_index]  <= w_tag;
      end else if (w_write_hit) begin
        r_data[w_index][w_bit_lo +: 8] <= WRITEDATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// Bench for data_cache: flat byte-memory reference, scoreboard of load data,
// behavioural block memory with variable latency.
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'h0;
  logic        MEM_BUSYWAIT = 1'b0;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Backing store (block granularity) and the CPU-visible byte view
  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  logic [7:0]  sb_q [$];

  int mem_lat_fixed = -1;
  int mem_cnt = 0;
  int mem_lat = 0;
  byte ev_q [$];
  logic [5:0]  last_wb_addr, last_fetch_addr;
  logic [31:0] last_wb_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // A reset throws away every cached byte, so the CPU view reverts to memory
  task automatic sync_ref_from_mem();
    for (int b = 0; b < 64; b++)
      for (int o = 0; o < 4; o++)
        ref_mem[b*4 + o] = mem[b][o*8 +: 8];
  endtask

  // Memory responder: decides MEM_BUSYWAIT on the negedge before each posedge
  always @(negedge CLK) begin
    if (!RESET || !(MEM_READ || MEM_WRITE)) begin
      mem_cnt = 0;
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = $urandom;
    end else begin
      if (mem_cnt == 0) begin
        mem_lat = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
        checks++;
        if (MEM_READ && MEM_WRITE) begin
          failures++;
          $display("FAIL mem_excl: MEM_READ=%0b MEM_WRITE=%0b required not both", MEM_READ, MEM_WRITE);
        end
        if (MEM_WRITE) begin
          ev_q.push_back("W");
          last_wb_addr = MEM_ADDRESS;
          last_wb_data = MEM_WRITEDATA;
          check("wb_data_coherent", MEM_WRITEDATA,
                {ref_mem[{MEM_ADDRESS, 2'd3}], ref_mem[{MEM_ADDRESS, 2'd2}],
                 ref_mem[{MEM_ADDRESS, 2'd1}], ref_mem[{MEM_ADDRESS, 2'd0}]});
        end else begin
          ev_q.push_back("R");
          last_fetch_addr = MEM_ADDRESS;
          check("fetch_addr", {26'd0, MEM_ADDRESS}, {26'd0, ADDRESS[7:2]});
        end
      end
      mem_cnt++;
      if (mem_cnt <= mem_lat) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = $urandom;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        else           MEM_READDATA = mem[MEM_ADDRESS];
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: a pure read completes where it is presented unstalled
  always @(negedge CLK) begin
    if (RESET && READ && !WRITE && !BUSYWAIT) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL load_unexpected: got 0x%0h with no pending load", READDATA);
      end else begin
        check("load_data", {24'd0, READDATA}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  // Issue one CPU access at posedge+1; returns at posedge+1 after it completes
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output int stalls);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    if (rd && !wr) sb_q.push_back(ref_mem[a]);
    stalls = 0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        failures++;
        $display("FAIL timeout: BUSYWAIT=%0b after %0d cycles, required 0", BUSYWAIT, stalls);
        summary();
      end
    end
    @(posedge CLK);
    if (wr) ref_mem[a] = d;
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int st;
    int n;
    logic rd, wr;
    logic [7:0] a, d;

    for (int b = 0; b < 64; b++) mem[b] = $urandom;
    mem[6'h09] = 32'hDDCCBBAA;
    sync_ref_from_mem();

    // Reset and idle outputs
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    check("rst_readdata", {24'd0, READDATA}, 32'd0);
    @(posedge CLK); #1;

    // Clean read miss, 5 busy cycles: 1 + 6 + 1 stall cycles
    mem_lat_fixed = 5;
    ev_q.delete();
    access(1'b1, 1'b0, 8'h25, 8'h00, st);
    check("clean_miss_stalls", st, 8);
    check("clean_miss_events", ev_q.size(), 1);
    check("clean_miss_addr", {26'd0, last_fetch_addr}, 32'h09);
    check("clean_miss_byte", {24'd0, ref_mem[8'h25]}, 32'hBB);

    // Write hit, then read it back
    access(1'b0, 1'b1, 8'h27, 8'h5A, st);
    check("write_hit_stalls", st, 0);
    access(1'b1, 1'b0, 8'h27, 8'h00, st);
    check("read_after_write_stalls", st, 0);

    // Dirty eviction: write-back strictly before fetch
    mem_lat_fixed = 3;
    ev_q.delete();
    access(1'b1, 1'b0, 8'h45, 8'h00, st);
    check("evict_events", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("evict_first_is_wb", {24'd0, ev_q[0]}, {24'd0, 8'("W")});
      check("evict_second_is_rd", {24'd0, ev_q[1]}, {24'd0, 8'("R")});
    end
    check("evict_wb_addr", {26'd0, last_wb_addr}, 32'h09);
    check("evict_wb_data", last_wb_data, 32'h5ACCBBAA);
    check("evict_fetch_addr", {26'd0, last_fetch_addr}, 32'h11);
    check("evict_stalls", st, 1 + 4 + 4 + 1);

    // Reset during a long fetch; the held read must miss again afterwards
    mem_lat_fixed = 20;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25;
    sb_q.push_back(ref_mem[8'h25]);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MEM_READ && n < 10);
    check("rst_fetch_reached", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("rst_fetch_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("rst_fetch_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    RESET = 1'b1;
    sync_ref_from_mem();
    mem_lat_fixed = 2;
    @(negedge CLK);
    check("rst_fetch_remiss", {31'd0, BUSYWAIT}, 32'd1);
    n = 0;
    while (BUSYWAIT && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("rst_fetch_complete", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    READ = 1'b0;

    // READ and WRITE together on a hit acts as a write
    access(1'b1, 1'b1, 8'h25, 8'h11, st);
    check("both_hi_stalls", st, 0);
    access(1'b1, 1'b0, 8'h25, 8'h00, st);
    check("both_hi_byte", {24'd0, ref_mem[8'h25]}, 32'h11);

    // Randomised traffic with a few tags per index to force conflicts
    mem_lat_fixed = -1;
    for (int i = 0; i < 400; i++) begin
      a  = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
      d  = 8'($urandom);
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      access(rd, wr, a, d, st);
    end

    // Final sweep: every byte of four tags read back
    for (int i = 0; i < 128; i++) begin
      a = 8'(i);
      access(1'b1, 1'b0, a, 8'h00, st);
    end

    repeat (3) @(posedge CLK);
    check("scoreboard_drained", sb_q.size(), 0);
    summary();
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
